hazard_detector: RTL and testbench



---
 rtl/controlmux_pkg.sv | 9 +
 rtl/hazard_detector_pkg.sv | 8 +
 rtl/hazard_detector_perf_cnt.sv | 35 +++
 rtl/hazard_detector.sv | 132 +++++++++++++
 tb/tb_hazard_detector.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/controlmux_pkg.sv
// Shared control-word mux select, consumed by the hazard controller and the forwarder.
package controlmux;

  typedef enum logic {
    normal = 1'b0,
    zero   = 1'b1
  } controlmux_sel_t;

endpackage

// File: rtl/hazard_detector_pkg.sv
// Register-index type and widths shared by the hazard controller files.
package hazard_detector_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] rv32i_reg;

endpackage

// File: rtl/hazard_detector_perf_cnt.sv
// Free-running event counter that wraps at 2^CNT_WIDTH; synchronous active-high clear.
module hazard_perf_cnt #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Next count: step by one on each qualifying event.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_detector.sv
// ID/EX hazard and stall controller: memory freeze, branch flush, load-use bubble,
// sticky memory-response tracking and performance counters.
module hazard_detector
  import hazard_detector_pkg::*;
  import controlmux::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  rv32i_reg             IF_ID_rs1_i,
  input  rv32i_reg             IF_ID_rs2_i,
  input  logic                 IF_ID_uses_rs1_i,
  input  logic                 IF_ID_uses_rs2_i,
  input  rv32i_reg             ID_EX_rd_i,
  input  logic                 ID_EX_mem_read_i,
  input  logic                 EX_br_taken_i,
  input  logic                 imem_read_i,
  input  logic                 imem_resp_i,
  input  logic                 dmem_read_i,
  input  logic                 dmem_write_i,
  input  logic                 dmem_resp_i,
  output logic                 pc_load_o,
  output logic                 IF_ID_load_o,
  output logic                 ID_EX_load_o,
  output logic                 EX_MEM_load_o,
  output logic                 MEM_WB_load_o,
  output controlmux_sel_t      controlmux_sel_o,
  output logic                 IF_ID_flush_o,
  output logic                 imem_mask_o,
  output logic                 dmem_mask_o,
  output logic                 imem_capture_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] bubble_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  logic imem_done_q, imem_done_d;
  logic dmem_done_q, dmem_done_d;
  logic ipend_s, dpend_s, mem_stall_s, lu_s;
  logic rs1_hit_s, rs2_hit_s;
  logic bubble_sel_s, flush_sel_s;

  assign ipend_s     = imem_read_i & ~imem_resp_i & ~imem_done_q;
  assign dpend_s     = (dmem_read_i | dmem_write_i) & ~dmem_resp_i & ~dmem_done_q;
  assign mem_stall_s = ipend_s | dpend_s;

  assign rs1_hit_s = (ID_EX_rd_i == IF_ID_rs1_i) & IF_ID_uses_rs1_i;
  assign rs2_hit_s = (ID_EX_rd_i == IF_ID_rs2_i) & IF_ID_uses_rs2_i;
  assign lu_s      = ID_EX_mem_read_i & (|ID_EX_rd_i) & (rs1_hit_s | rs2_hit_s);

  // Priority select: memory freeze, then branch flush, then load-use bubble.
  always_comb begin
    pc_load_o        = 1'b1;
    IF_ID_load_o     = 1'b1;
    ID_EX_load_o     = 1'b1;
    EX_MEM_load_o    = 1'b1;
    MEM_WB_load_o    = 1'b1;
    controlmux_sel_o = normal;
    IF_ID_flush_o    = 1'b0;
    flush_sel_s      = 1'b0;
    bubble_sel_s     = 1'b0;
    if (mem_stall_s) begin
      pc_load_o     = 1'b0;
      IF_ID_load_o  = 1'b0;
      ID_EX_load_o  = 1'b0;
      EX_MEM_load_o = 1'b0;
      MEM_WB_load_o = 1'b0;
    end else if (EX_br_taken_i) begin
      IF_ID_flush_o    = 1'b1;
      controlmux_sel_o = zero;
      flush_sel_s      = 1'b1;
    end else if (lu_s) begin
      pc_load_o        = 1'b0;
      IF_ID_load_o     = 1'b0;
      controlmux_sel_o = zero;
      bubble_sel_s     = 1'b1;
    end else begin
      controlmux_sel_o = normal;
    end
  end

  // Done bits remember a response that arrived while the other port kept us frozen.
  always_comb begin
    imem_done_d = 1'b0;
    dmem_done_d = 1'b0;
    if (mem_stall_s) begin
      imem_done_d = imem_done_q | imem_resp_i;
      dmem_done_d = dmem_done_q | dmem_resp_i;
    end else begin
      imem_done_d = 1'b0;
      dmem_done_d = 1'b0;
    end
  end

  // Done-bit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
    end else begin
      imem_done_q <= imem_done_d;
      dmem_done_q <= dmem_done_d;
    end
  end

  assign imem_mask_o    = imem_done_q;
  assign dmem_mask_o    = dmem_done_q;
  assign imem_capture_o = imem_resp_i & mem_stall_s;

  hazard_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (mem_stall_s),
    .cnt_o (stall_cnt_o)
  );

  hazard_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (bubble_sel_s),
    .cnt_o (bubble_cnt_o)
  );

  hazard_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_sel_s),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_detector.sv
// Bench for hazard_detector: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_hazard_detector;
  import controlmux::*;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, ld, br;
  logic iread, iresp, dread, dwrite, dresp;

  logic pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  controlmux_sel_t sel;
  logic ifid_flush, imask, dmask, icap;
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: sticky completions and event tallies.
  bit m_idone, m_ddone;
  bit [31:0] m_stall, m_bubble, m_flush;

  always #5 clk = ~clk;

  hazard_detector #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs1_i(rs1), .IF_ID_rs2_i(rs2),
    .IF_ID_uses_rs1_i(u1), .IF_ID_uses_rs2_i(u2),
    .ID_EX_rd_i(rd), .ID_EX_mem_read_i(ld), .EX_br_taken_i(br),
    .imem_read_i(iread), .imem_resp_i(iresp),
    .dmem_read_i(dread), .dmem_write_i(dwrite), .dmem_resp_i(dresp),
    .pc_load_o(pc_load), .IF_ID_load_o(ifid_load), .ID_EX_load_o(idex_load),
    .EX_MEM_load_o(exmem_load), .MEM_WB_load_o(memwb_load),
    .controlmux_sel_o(sel), .IF_ID_flush_o(ifid_flush),
    .imem_mask_o(imask), .dmem_mask_o(dmask), .imem_capture_o(icap),
    .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt)
  );

  // Scenario classification: 0 frozen on memory, 1 branch flush, 2 load-use bubble, 3 run.
  function automatic int classify(bit idone, bit ddone);
    bit waiting_i, waiting_d, hazard;
    waiting_i = iread && !iresp && !idone;
    waiting_d = (dread || dwrite) && !dresp && !ddone;
    hazard = ld && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    if (waiting_i || waiting_d) return 0;
    if (br) return 1;
    if (hazard) return 2;
    return 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] loads();
    return {pc_load, ifid_load, idex_load, exmem_load, memwb_load};
  endfunction

  // Model advances on each edge from the inputs held during the cycle.
  always @(posedge clk) begin
    int act;
    act = classify(m_idone, m_ddone);
    if (rst) begin
      m_idone = 1'b0; m_ddone = 1'b0;
      m_stall = 32'd0; m_bubble = 32'd0; m_flush = 32'd0;
    end else begin
      if (act == 0) begin
        if (iresp) m_idone = 1'b1;
        if (dresp) m_ddone = 1'b1;
        m_stall = m_stall + 32'd1;
      end else begin
        m_idone = 1'b0;
        m_ddone = 1'b0;
      end
      if (act == 1) m_flush = m_flush + 32'd1;
      if (act == 2) m_bubble = m_bubble + 32'd1;
    end
  end

  // Compare every cycle mid-period, after inputs and registers have settled.
  always @(negedge clk) begin
    int act;
    logic [4:0] exp_loads;
    if (!rst) begin
      act = classify(m_idone, m_ddone);
      case (act)
        0: exp_loads = 5'b00000;
        2: exp_loads = 5'b00111;
        default: exp_loads = 5'b11111;
      endcase
      chk("loads", {27'd0, loads()}, {27'd0, exp_loads});
      chk("sel", {31'd0, sel == zero}, {31'd0, (act == 1 || act == 2)});
      chk("flush", {31'd0, ifid_flush}, {31'd0, act == 1});
      chk("imask", {31'd0, imask}, {31'd0, m_idone});
      chk("dmask", {31'd0, dmask}, {31'd0, m_ddone});
      chk("capture", {31'd0, icap}, {31'd0, iresp && act == 0});
      chk("stall_cnt", stall_cnt, m_stall);
      chk("bubble_cnt", bubble_cnt, m_bubble);
      chk("flush_cnt", flush_cnt, m_flush);
    end
  end

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; u1 = 1'b0; u2 = 1'b0; ld = 1'b0; br = 1'b0;
    iread = 1'b0; iresp = 1'b0; dread = 1'b0; dwrite = 1'b0; dresp = 1'b0;
  endtask

  // Advance one clock; new inputs apply just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step(); step();
    rst = 1'b0;
    #1;

    // Idle after reset.
    chk("rst_loads", {27'd0, loads()}, 32'h1f);
    chk("rst_sel", {31'd0, sel == zero}, 32'd0);
    chk("rst_cnt", stall_cnt | bubble_cnt | flush_cnt, 32'd0);
    chk("rst_mask", {30'd0, imask, dmask}, 32'd0);

    // Load-use on rs2 gives one bubble.
    step();
    rd = 5'd5; ld = 1'b1; rs2 = 5'd5; u2 = 1'b1; rs1 = 5'd7; u1 = 1'b1;
    #1;
    chk("lu_loads", {27'd0, loads()}, 32'h07);
    chk("lu_sel", {31'd0, sel == zero}, 32'd1);
    step();
    ld = 1'b0;
    #1;
    chk("lu_bubble_cnt", bubble_cnt, 32'd1);
    chk("lu_release", {27'd0, loads()}, 32'h1f);
    rd = 5'd0; ld = 1'b1; rs2 = 5'd0;
    #1;
    chk("x0_no_stall", {27'd0, loads()}, 32'h1f);

    // Branch and load-use together: branch wins.
    do_reset();
    rd = 5'd5; ld = 1'b1; rs2 = 5'd5; u2 = 1'b1; br = 1'b1;
    #1;
    chk("brlu_flush", {31'd0, ifid_flush}, 32'd1);
    chk("brlu_sel", {31'd0, sel == zero}, 32'd1);
    chk("brlu_pc", {31'd0, pc_load}, 32'd1);
    step();
    idle();
    #1;
    chk("brlu_flush_cnt", flush_cnt, 32'd1);
    chk("brlu_bubble_cnt", bubble_cnt, 32'd0);

    // I-miss and D-miss overlap; requests raised in cycle 1.
    do_reset();
    iread = 1'b1; dread = 1'b1;                       // cycle 1
    step();                                           // cycle 2
    step(); iresp = 1'b1; #1;                         // cycle 3
    chk("ov_capture", {31'd0, icap}, 32'd1);
    chk("ov_frozen3", {27'd0, loads()}, 32'h00);
    for (int c = 4; c <= 5; c++) begin
      step(); iresp = 1'b0; #1;
      chk("ov_imask", {31'd0, imask}, 32'd1);
      chk("ov_frozen", {27'd0, loads()}, 32'h00);
    end
    step(); dresp = 1'b1; #1;                         // cycle 6
    chk("ov_imask6", {31'd0, imask}, 32'd1);
    chk("ov_release", {27'd0, loads()}, 32'h1f);
    step(); idle(); #1;                               // cycle 7
    chk("ov_masks_clear", {30'd0, imask, dmask}, 32'd0);
    chk("ov_stall_cnt", stall_cnt, 32'd5);

    // Taken branch held during a 4-cycle D-miss.
    do_reset();
    dread = 1'b1; br = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("brstall_noflush", {31'd0, ifid_flush}, 32'd0);
      step();
    end
    dresp = 1'b1;
    #1;
    chk("brstall_flush", {31'd0, ifid_flush}, 32'd1);
    chk("brstall_sel", {31'd0, sel == zero}, 32'd1);
    step(); idle(); #1;
    chk("brstall_flush_cnt", flush_cnt, 32'd1);
    chk("brstall_stall_cnt", stall_cnt, 32'd4);

    // Reset in the middle of a stall clears done bits and counters.
    do_reset();
    iread = 1'b1; dread = 1'b1; iresp = 1'b1;        // stall cycle 1, I responds
    step(); iresp = 1'b0; rst = 1'b1; #1;            // stall cycle 2
    chk("rst_mid_imask_before", {31'd0, imask}, 32'd1);
    step(); rst = 1'b0; #1;
    chk("rst_mid_imask", {31'd0, imask}, 32'd0);
    chk("rst_mid_cnt", stall_cnt | bubble_cnt | flush_cnt, 32'd0);
    idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step();
      rst    = ($urandom_range(0, 199) == 0);
      rs1    = 5'($urandom_range(0, 3));
      rs2    = 5'($urandom_range(0, 3));
      rd     = 5'($urandom_range(0, 3));
      u1     = 1'($urandom);
      u2     = 1'($urandom);
      ld     = ($urandom_range(0, 2) == 0);
      br     = ($urandom_range(0, 5) == 0);
      iread  = ($urandom_range(0, 2) != 0);
      iresp  = ($urandom_range(0, 2) == 0);
      dread  = ($urandom_range(0, 3) == 0);
      dwrite = ($urandom_range(0, 5) == 0);
      dresp  = ($urandom_range(0, 2) == 0);
    end
    step();
    idle();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
